// File: rtl/ascii_text_writer.sv
// Cursor-based character writer: turns a valid/ready character stream into
// single-cycle {ascii, rgb} writes to the text buffer, with wrap and clear.
module ascii_text_writer #(
  parameter int          COLS        = 80,
  parameter int          ROWS        = 60,
  parameter int          ADDR_W      = 13,
  parameter logic [23:0] CLEAR_RGB   = 24'h000000,
  parameter int          SCROLL_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      char_valid,
  output logic                      char_ready,
  input  logic [7:0]                char_data,
  input  logic [23:0]               char_rgb,
  input  logic                      clear_req,
  output logic                      busy,
  output logic                      ascii_write_en,
  output logic [31:0]               ascii_input,
  output logic [ADDR_W-1:0]         ascii_write_address,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = ADDR_W + 1;
  localparam int TOTAL = COLS * ROWS;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(TOTAL);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_SP = 8'h20;

  // Handshake: a character transfers on a rising edge where char_valid and
  // char_ready are both high; the source must hold data stable until then.
  typedef enum logic [1:0] {IDLE, CLEAR, WRAPCLR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   lin, lin_nxt;
  logic [COL_W-1:0]    col_nxt;
  logic [ROW_W-1:0]    row_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                we_nxt;
  logic [31:0]         data_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                adv_row;

  assign char_ready = (state == IDLE) && !clear_req;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      lin                 <= '0;
      cursor_col          <= '0;
      cursor_row          <= '0;
      cnt                 <= '0;
      ascii_write_en      <= 1'b0;
      ascii_input         <= '0;
      ascii_write_address <= '0;
    end else begin
      state               <= state_nxt;
      lin                 <= lin_nxt;
      cursor_col          <= col_nxt;
      cursor_row          <= row_nxt;
      cnt                 <= cnt_nxt;
      ascii_write_en      <= we_nxt;
      ascii_input         <= data_nxt;
      ascii_write_address <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lin_nxt   = lin;
    col_nxt   = cursor_col;
    row_nxt   = cursor_row;
    cnt_nxt   = cnt;
    we_nxt    = 1'b0;
    data_nxt  = ascii_input;
    addr_nxt  = ascii_write_address;
    adv_row   = 1'b0;

    case (state)
      IDLE: begin
        if (clear_req) begin
          // The first clear write goes out with the request itself, so the
          // whole clear takes exactly one cycle per buffer location.
          state_nxt = CLEAR;
          we_nxt    = 1'b1;
          addr_nxt  = '0;
          data_nxt  = {CH_SP, CLEAR_RGB};
          cnt_nxt   = CNT_ONE;
          lin_nxt   = '0;
          col_nxt   = '0;
          row_nxt   = '0;
        end else if (char_valid) begin
          case (char_data)
            CH_LF: begin
              col_nxt = '0;
              lin_nxt = lin - ADDR_W'(cursor_col) + ADDR_W'(COLS);
              adv_row = 1'b1;
            end
            CH_CR: begin
              col_nxt = '0;
              lin_nxt = lin - ADDR_W'(cursor_col);
            end
            CH_BS: begin
              if (cursor_col != '0) begin
                col_nxt  = cursor_col - COL_ONE;
                lin_nxt  = lin - ADDR_ONE;
                we_nxt   = 1'b1;
                addr_nxt = lin - ADDR_ONE;
                data_nxt = {CH_SP, char_rgb};
              end
            end
            default: begin
              we_nxt   = 1'b1;
              addr_nxt = lin;
              data_nxt = {char_data, char_rgb};
              lin_nxt  = lin + ADDR_ONE;
              if (cursor_col == COL_LAST) begin
                col_nxt = '0;
                adv_row = 1'b1;
              end else begin
                col_nxt = cursor_col + COL_ONE;
              end
            end
          endcase

          if (adv_row) begin
            if (cursor_row == ROW_LAST) begin
              row_nxt = '0;
              col_nxt = '0;
              lin_nxt = '0;
              if (SCROLL_MODE != 0) begin
                state_nxt = WRAPCLR;
                cnt_nxt   = '0;
              end
            end else begin
              row_nxt = cursor_row + ROW_ONE;
            end
          end
        end
      end

      CLEAR, WRAPCLR: begin
        if (cnt == CNT_END) begin
          state_nxt = IDLE;
          lin_nxt   = '0;
          col_nxt   = '0;
          row_nxt   = '0;
        end else begin
          we_nxt   = 1'b1;
          addr_nxt = cnt[ADDR_W-1:0];
          data_nxt = {CH_SP, CLEAR_RGB};
          cnt_nxt  = cnt + CNT_ONE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/ascii_text_writer.md
Name: ascii_text_writer

Overview:
- Cursor-based character stream front-end for ascii_master_controller.
- Accepts characters one at a time over a valid/ready handshake and tracks a (row, col) cursor.
- Converts each character into a single-cycle write of {ascii, rgb} to the text buffer, with line wrap, control-code handling, screen wrap and a hardware clear.
- Replaces hand-sequenced address/string counters in top-level logic.

Parameters:
- COLS, 80, characters per row.
- ROWS, 60, rows per screen.
- ADDR_W, 13, width of ascii_write_address; COLS*ROWS must be at most 2**ADDR_W.
- CLEAR_RGB, 24'h000000, colour written with spaces during a clear.
- SCROLL_MODE, 0, action when the cursor passes the last row: 0 wraps to row 0; 1 performs a full clear, then homes the cursor.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst  input  1  asynchronous active-low reset.
- char_valid  input  1  char_data/char_rgb are valid.
- char_ready  output  1  block can accept a character this cycle.
- char_data  input  8  ASCII code.
- char_rgb  input  24  foreground colour for this character.
- clear_req  input  1  single-cycle pulse: clear screen and home the cursor.
- busy  output  1  clear in progress.
- ascii_write_en  output  1  buffer write strobe.
- ascii_input  output  32  {ascii[7:0], rgb[23:0]} to the buffer.
- ascii_write_address  output  ADDR_W  linear address, row*COLS+col.
- cursor_col  output  $clog2(COLS)  current column.
- cursor_row  output  $clog2(ROWS)  current row.

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: ascii_write_en=0, ascii_input=0, ascii_write_address=0, cursor_col=0, cursor_row=0, busy=0.
  - State=IDLE.
  - Reset mid-clear or mid-write aborts immediately; no further writes are issued.
- States: IDLE, CLEAR, WRAPCLR (the clear triggered by SCROLL_MODE=1).
- char_ready (combinational) = (state==IDLE) && !clear_req. A transfer occurs when char_valid && char_ready on a rising edge.
- Write latency: for a transfer at edge N, ascii_write_en is high for exactly the cycle following edge N, with address and data registered at edge N. Back-to-back transfers produce one write per cycle.
- The cursor is tracked as a linear address counter plus col/row counters. No multiplier is used.
- Character handling:
  - 0x0A (LF): no write; col=0; row+1.
  - 0x0D (CR): no write; col=0.
  - 0x08 (BS), col>0: col-1; write {0x20, char_rgb} at the new position.
  - 0x08 (BS), col==0: no write, no cursor change.
  - Any other code: written verbatim at the cursor; then col+1.
  - At col==COLS-1, the advance gives col=0, row+1.
- Row overflow (row+1 == ROWS):
  - SCROLL_MODE=0: row=0. Existing contents are kept; they are overwritten as new characters arrive.
  - SCROLL_MODE=1: enter WRAPCLR; same sequence as CLEAR.
- CLEAR (from clear_req in IDLE):
  - busy=1; char_ready=0.
  - Writes {0x20, CLEAR_RGB} to addresses 0..COLS*ROWS-1, one per cycle, ascending, with ascii_write_en high on each.
  - After the last address: cursor=(0,0), busy=0, back to IDLE.
  - Total time: COLS*ROWS write cycles.
- Simultaneous clear_req and char_valid: clear wins; the character is not accepted (ready=0) and must be held by the source.
- clear_req during CLEAR or WRAPCLR is ignored.
- cursor_col/cursor_row update on the same edge as the transfer and always reflect the next write position.
- Addresses never exceed COLS*ROWS-1.

Test Plan:
- Reset, then stream "Hi" with rgb=FFFFFF, valid held high → writes (addr 0, {0x48,FFFFFF}) then (addr 1, {0x69,FFFFFF}) on consecutive cycles; cursor=(0,2).
- 80 'A's, then 'B' → 'B' written at addr 80; cursor=(1,1).
- "AB", 0x08, 0x08, 0x08 → space written at addr 1, then addr 0; third BS produces no write; cursor=(0,0).
- Cursor at (59,79), SCROLL_MODE=0, send 'Z' → write at addr 4799; cursor=(0,0). With SCROLL_MODE=1: 4800 clear writes, busy high throughout, cursor=(0,0), ready=0 until done.
- clear_req pulse coincident with char_valid → char_ready=0 that cycle; 4800 writes of {0x20,000000} at addresses 0..4799; the held character is then accepted and written at addr 0.
- rst asserted mid-clear at addr 100 → ascii_write_en=0 immediately; all outputs at reset values; no writes after release until new input arrives.
